// File: rtl/xgmac_pause_stats.sv
// XGMAC glue: FIFO-level driven XOFF/XON pause generation, saturating RX/TX statistics, MAC config vectors.
// Optional feature macro: XGMAC_PAUSE_XON_EN (explicit XON frame with zero quanta when paused traffic resumes).
module xgmac_pause_stats #(
    parameter int          CNT_W        = 32,
    parameter int          LVL_W        = 10,
    parameter int          HI_WM        = 768,
    parameter int          LO_WM        = 256,
    parameter logic [15:0] PAUSE_QUANTA = 16'hFFFF,
    parameter int          REFRESH_CYC  = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LVL_W-1:0] fifo_level,
    input  logic             tx_enable,
    input  logic             rx_enable,
    input  logic             rx_statistics_valid,
    input  logic [29:0]      rx_statistics_vector,
    input  logic             tx_statistics_valid,
    input  logic [25:0]      tx_statistics_vector,
    input  logic [1:0]       status_vector,
    input  logic [2:0]       stat_sel,
    input  logic             stat_rd,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] stat_data,
    output logic             pause_req,
    output logic [15:0]      pause_val,
    output logic [79:0]      rx_configuration_vector,
    output logic [79:0]      tx_configuration_vector
);

    localparam int               RC_W    = $clog2(REFRESH_CYC);
    localparam logic [RC_W-1:0]  RC_LAST = RC_W'(REFRESH_CYC - 1);
    localparam logic [LVL_W-1:0] HI_LVL  = LVL_W'(HI_WM);
    localparam logic [LVL_W-1:0] LO_LVL  = LVL_W'(LO_WM);

    typedef enum logic [1:0] {S_IDLE, S_XOFF, S_HOLD, S_XON} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [RC_W-1:0]  r_refresh;
    logic [RC_W-1:0]  w_refresh_next;
    logic             r_pause_req;
    logic [15:0]      r_pause_val;
    logic             w_pulse_next;
    logic [1:0]       r_status_prev;
    logic [1:0]       w_rise;
    logic [CNT_W-1:0] w_inc [8];
    logic [CNT_W-1:0] w_cnt [8];
    logic [CNT_W-1:0] r_stat_data;
    logic [79:0]      r_rx_cfg;
    logic [79:0]      r_tx_cfg;
    logic             w_rx_good;
    logic             w_tx_good;
    logic             w_unused;

    assign w_rx_good = rx_statistics_valid & rx_statistics_vector[0];
    assign w_tx_good = tx_statistics_valid & tx_statistics_vector[0];
    assign w_rise    = status_vector & ~r_status_prev;
    assign w_unused  = ^{rx_statistics_vector[29:19], rx_statistics_vector[4:2],
                         tx_statistics_vector[25:19], tx_statistics_vector[4:2]};

    assign w_inc[0] = CNT_W'(w_rx_good);
    assign w_inc[1] = CNT_W'(rx_statistics_valid & rx_statistics_vector[1]);
    assign w_inc[2] = w_rx_good ? CNT_W'(rx_statistics_vector[18:5]) : '0;
    assign w_inc[3] = CNT_W'(w_tx_good);
    assign w_inc[4] = CNT_W'(tx_statistics_valid & tx_statistics_vector[1]);
    assign w_inc[5] = w_tx_good ? CNT_W'(tx_statistics_vector[18:5]) : '0;
    assign w_inc[6] = CNT_W'(w_rise[0]);
    assign w_inc[7] = CNT_W'(w_rise[1]);

    // A clear that coincides with an increment keeps the increment so no event is lost.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_cnt
            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W:0]   w_sum;
            logic             w_clr;

            assign w_sum      = {1'b0, r_cnt} + {1'b0, w_inc[gi]};
            assign w_clr      = stat_clr && (stat_sel == 3'(gi));
            assign w_cnt[gi]  = r_cnt;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (w_clr) begin
                    r_cnt <= w_inc[gi];
                end else if (w_sum[CNT_W]) begin
                    r_cnt <= '1;
                end else begin
                    r_cnt <= w_sum[CNT_W-1:0];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_status_prev <= '0;
            r_stat_data   <= '0;
            r_rx_cfg      <= '0;
            r_tx_cfg      <= '0;
        end else begin
            r_status_prev <= status_vector;
            if (stat_rd) begin
                r_stat_data <= w_cnt[stat_sel];
            end
            r_rx_cfg <= {78'd0, rx_enable, 1'b0};
            r_tx_cfg <= {74'd0, 1'b1, 3'd0, tx_enable, 1'b0};
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_refresh_next = r_refresh;
        case (r_state)
            S_IDLE: begin
                if (fifo_level >= HI_LVL) begin
                    w_state_next = S_XOFF;
                end
            end
            S_XOFF: begin
                w_refresh_next = '0;
                w_state_next   = S_HOLD;
            end
            S_HOLD: begin
                w_refresh_next = r_refresh + 1'b1;
                if (fifo_level < LO_LVL) begin
                    w_state_next = S_XON;
                end else if (r_refresh == RC_LAST) begin
                    w_state_next = S_XOFF;
                end
            end
            S_XON: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        if (!rx_enable) begin
            w_state_next = S_IDLE;
        end
    end

`ifdef XGMAC_PAUSE_XON_EN
    assign w_pulse_next = (w_state_next == S_XOFF) || (w_state_next == S_XON);
`else
    assign w_pulse_next = (w_state_next == S_XOFF);
`endif

    // Pulse and quanta are registered together so pause_val is valid in the pause_req cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_refresh   <= '0;
            r_pause_req <= 1'b0;
            r_pause_val <= '0;
        end else begin
            r_state     <= w_state_next;
            r_refresh   <= w_refresh_next;
            r_pause_req <= w_pulse_next;
            if (w_state_next == S_XOFF) begin
                r_pause_val <= PAUSE_QUANTA;
            end
`ifdef XGMAC_PAUSE_XON_EN
            else if (w_state_next == S_XON) begin
                r_pause_val <= 16'h0000;
            end
`endif
        end
    end

    assign stat_data               = r_stat_data;
    assign pause_req               = r_pause_req;
    assign pause_val               = r_pause_val;
    assign rx_configuration_vector = r_rx_cfg;
    assign tx_configuration_vector = r_tx_cfg;

endmodule

// File: tb/tb_xgmac_pause_stats.sv
// Self-checking bench for xgmac_pause_stats: table-driven config/stat vectors plus pause and saturation sequences.
`timescale 1ns/1ps
module tb_xgmac_pause_stats;

    localparam int REFRESH_CYC = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  fifo_level = '0;
    logic        tx_enable = 1'b0;
    logic        rx_enable = 1'b0;
    logic        rx_statistics_valid = 1'b0;
    logic [29:0] rx_statistics_vector = '0;
    logic        tx_statistics_valid = 1'b0;
    logic [25:0] tx_statistics_vector = '0;
    logic [1:0]  status_vector = '0;
    logic [2:0]  stat_sel = '0;
    logic        stat_rd = 1'b0;
    logic        stat_clr = 1'b0;
    logic [15:0] stat_data;
    logic        pause_req;
    logic [15:0] pause_val;
    logic [79:0] rx_configuration_vector;
    logic [79:0] tx_configuration_vector;

    xgmac_pause_stats #(.CNT_W(16), .REFRESH_CYC(REFRESH_CYC)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .fifo_level              (fifo_level),
        .tx_enable               (tx_enable),
        .rx_enable               (rx_enable),
        .rx_statistics_valid     (rx_statistics_valid),
        .rx_statistics_vector    (rx_statistics_vector),
        .tx_statistics_valid     (tx_statistics_valid),
        .tx_statistics_vector    (tx_statistics_vector),
        .status_vector           (status_vector),
        .stat_sel                (stat_sel),
        .stat_rd                 (stat_rd),
        .stat_clr                (stat_clr),
        .stat_data               (stat_data),
        .pause_req               (pause_req),
        .pause_val               (pause_val),
        .rx_configuration_vector (rx_configuration_vector),
        .tx_configuration_vector (tx_configuration_vector)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rx_en;
        logic        tx_en;
        logic [79:0] exp_rx;
        logic [79:0] exp_tx;
    } cfg_vec_t;

    typedef struct {
        logic        good;
        logic        bad;
        logic [13:0] len;
        logic [15:0] exp_good;
        logic [15:0] exp_bad;
        logic [15:0] exp_bytes;
    } rx_vec_t;

    int errors = 0;
    int checks = 0;
    logic [15:0] sb_q[$];
    string       sb_name_q[$];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            $display("ok   %s = %0h", nm, act);
        end
    endtask

    // Read (optionally with clear): expectation queued at drive time, compared when stat_data updates.
    task automatic rd(input logic [2:0] sel, input logic clr, input logic [15:0] exp, input string nm);
        stat_sel = sel;
        stat_rd  = 1'b1;
        stat_clr = clr;
        sb_q.push_back(exp);
        sb_name_q.push_back(nm);
        tick;
        stat_rd  = 1'b0;
        stat_clr = 1'b0;
        chk(sb_name_q.pop_front(), stat_data, sb_q.pop_front());
    endtask

    task automatic rx_pulse(input logic good, input logic bad, input logic [13:0] len);
        rx_statistics_valid  = 1'b1;
        rx_statistics_vector = {11'h7FF, len, 3'b111, bad, good};
    endtask

    task automatic wait_pulse(input int maxc, output int n, output bit got);
        got = 1'b0;
        n   = 0;
        while (!got && n < maxc) begin
            tick;
            n++;
            if (pause_req) got = 1'b1;
        end
    endtask

    cfg_vec_t cfg_tab[4];
    rx_vec_t  rx_tab[7];
    int       n;
    bit       got;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cfg_tab[0] = '{1'b0, 1'b0, 80'h0, 80'h20};
        cfg_tab[1] = '{1'b1, 1'b0, 80'h2, 80'h20};
        cfg_tab[2] = '{1'b0, 1'b1, 80'h0, 80'h22};
        cfg_tab[3] = '{1'b1, 1'b1, 80'h2, 80'h22};

        rx_tab[0] = '{1'b1, 1'b0, 14'd64,  16'd1, 16'd0, 16'd64};
        rx_tab[1] = '{1'b1, 1'b0, 14'd64,  16'd2, 16'd0, 16'd128};
        rx_tab[2] = '{1'b1, 1'b0, 14'd64,  16'd3, 16'd0, 16'd192};
        rx_tab[3] = '{1'b1, 1'b0, 14'd64,  16'd4, 16'd0, 16'd256};
        rx_tab[4] = '{1'b0, 1'b1, 14'd100, 16'd4, 16'd1, 16'd256};
        rx_tab[5] = '{1'b1, 1'b1, 14'd10,  16'd5, 16'd2, 16'd266};
        rx_tab[6] = '{1'b0, 1'b0, 14'd50,  16'd5, 16'd2, 16'd266};

        // Reset state
        repeat (3) tick;
        chk("rst_pause_req", pause_req, 0);
        chk("rst_pause_val", pause_val, 0);
        chk("rst_stat_data", stat_data, 0);
        chk("rst_rx_cfg", rx_configuration_vector, 0);
        chk("rst_tx_cfg", tx_configuration_vector, 0);
        rst = 1'b0;

        // Config vectors follow enables one cycle later
        for (int i = 0; i < 4; i++) begin
            rx_enable = cfg_tab[i].rx_en;
            tx_enable = cfg_tab[i].tx_en;
            tick;
            chk($sformatf("cfg%0d_rx", i), rx_configuration_vector, cfg_tab[i].exp_rx);
            chk($sformatf("cfg%0d_tx", i), tx_configuration_vector, cfg_tab[i].exp_tx);
        end

        // RX statistics rows
        for (int i = 0; i < 7; i++) begin
            rx_pulse(rx_tab[i].good, rx_tab[i].bad, rx_tab[i].len);
            tick;
            rx_statistics_valid = 1'b0;
            rd(3'd0, 1'b0, rx_tab[i].exp_good,  $sformatf("rx%0d_good", i));
            rd(3'd1, 1'b0, rx_tab[i].exp_bad,   $sformatf("rx%0d_bad", i));
            rd(3'd2, 1'b0, rx_tab[i].exp_bytes, $sformatf("rx%0d_bytes", i));
        end

        // Clear coincident with increment loads the increment; rd+clr returns pre-clear value
        stat_sel = 3'd0;
        stat_clr = 1'b1;
        rx_pulse(1'b1, 1'b0, 14'd64);
        tick;
        stat_clr = 1'b0;
        rx_statistics_valid = 1'b0;
        rd(3'd0, 1'b0, 16'd1, "clr_inc_good");
        stat_sel = 3'd2;
        stat_clr = 1'b1;
        rx_pulse(1'b1, 1'b0, 14'd64);
        tick;
        stat_clr = 1'b0;
        rx_statistics_valid = 1'b0;
        rd(3'd2, 1'b0, 16'd64, "clr_inc_bytes");
        rd(3'd0, 1'b1, 16'd2, "rdclr_old");
        rd(3'd0, 1'b0, 16'd0, "rdclr_after");

        // Fault rising edges
        status_vector = 2'b10; tick;
        status_vector = 2'b00; tick;
        status_vector = 2'b10;
        repeat (5) tick;
        rd(3'd7, 1'b0, 16'd2, "remote_fault_edges");
        rd(3'd6, 1'b0, 16'd0, "local_fault_none");
        status_vector = 2'b11;
        repeat (3) tick;
        rd(3'd6, 1'b0, 16'd1, "local_fault_one");
        rd(3'd7, 1'b0, 16'd2, "remote_fault_held");
        status_vector = 2'b00;
        tick;

        // Pause: XOFF, periodic refresh (one XOFF cycle plus REFRESH_CYC HOLD cycles), then release
        fifo_level = 10'd800;
        wait_pulse(8, n, got);
        chk("xoff_seen", got, 1);
        chk("xoff_latency", n, 1);
        chk("xoff_val", pause_val, 16'hFFFF);
        for (int r = 0; r < 2; r++) begin
            wait_pulse(REFRESH_CYC + 10, n, got);
            chk($sformatf("refresh%0d_seen", r), got, 1);
            chk($sformatf("refresh%0d_gap", r), n, REFRESH_CYC + 1);
            chk($sformatf("refresh%0d_val", r), pause_val, 16'hFFFF);
        end
        repeat (5) tick;
        fifo_level = 10'd100;
        wait_pulse(10, n, got);
`ifdef XGMAC_PAUSE_XON_EN
        chk("xon_seen", got, 1);
        chk("xon_latency", n, 1);
        chk("xon_val", pause_val, 16'h0000);
`else
        chk("xon_absent", got, 0);
        chk("xon_val_kept", pause_val, 16'hFFFF);
`endif
        fifo_level = 10'd500;
        wait_pulse(50, n, got);
        chk("idle_mid_level", got, 0);

        // rx_enable drop leaves pause with no XON and blocks new XOFF
        fifo_level = 10'd800;
        wait_pulse(8, n, got);
        chk("xoff2_seen", got, 1);
        repeat (3) tick;
        rx_enable  = 1'b0;
        fifo_level = 10'd100;
        wait_pulse(20, n, got);
        chk("rxdis_no_xon", got, 0);
        fifo_level = 10'd800;
        wait_pulse(20, n, got);
        chk("rxdis_no_xoff", got, 0);
        fifo_level = 10'd0;
        rx_enable  = 1'b1;
        repeat (2) tick;

        // Async reset while in HOLD, then fresh XOFF
        fifo_level = 10'd800;
        wait_pulse(8, n, got);
        chk("xoff3_seen", got, 1);
        repeat (3) tick;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_pause_req", pause_req, 0);
        chk("midrst_pause_val", pause_val, 0);
        chk("midrst_rx_cfg", rx_configuration_vector, 0);
        chk("midrst_tx_cfg", tx_configuration_vector, 0);
        tick;
        tick;
        rst = 1'b0;
        wait_pulse(8, n, got);
        chk("post_rst_xoff", got, 1);
        chk("post_rst_latency", n, 1);
        chk("post_rst_val", pause_val, 16'hFFFF);
        fifo_level = 10'd0;
        rd(3'd7, 1'b0, 16'd0, "post_rst_sel7");

        // TX good counter saturation at 16 bits
        tx_statistics_valid  = 1'b1;
        tx_statistics_vector = {7'h7F, 14'd1, 3'b111, 1'b0, 1'b1};
        repeat (65534) tick;
        tx_statistics_valid = 1'b0;
        rd(3'd3, 1'b0, 16'hFFFE, "tx_good_below_sat");
        tx_statistics_valid = 1'b1;
        tick;
        tx_statistics_valid = 1'b0;
        rd(3'd3, 1'b0, 16'hFFFF, "tx_good_at_sat");
        tx_statistics_valid = 1'b1;
        repeat (4465) tick;
        tx_statistics_valid = 1'b0;
        rd(3'd3, 1'b0, 16'hFFFF, "tx_good_no_wrap");
        rd(3'd5, 1'b0, 16'hFFFF, "tx_bytes_sat");
        rd(3'd4, 1'b0, 16'd0, "tx_bad_zero");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
